// File: rtl/jalr_resolve.sv
// Commit-side JALR resolver: dequeues the JALR queue head, compares the computed
// target against the prediction, and flushes/redirects fetch on a mismatch.
module jalr_resolve #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             commit_jalr,
  input  logic             head_ready,
  input  logic [31:0]      jalr_actual_address,
  input  logic [31:0]      jalr_taken_address,
  output logic             jalrq_rd_en,
  output logic             jalr_done,
  output logic             flush,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  input  logic             redirect_ack,
  output logic [CNT_W-1:0] jalr_total,
  output logic [CNT_W-1:0] jalr_mispredict
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    CHECK,
    REDIRECT,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      tgt_q, tgt_d;
  logic [31:0]      pred_q, pred_d;
  logic [31:0]      redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic [CNT_W-1:0] misp_q, misp_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      tgt_q         <= '0;
      pred_q        <= '0;
      redirect_pc_q <= '0;
      total_q       <= '0;
      misp_q        <= '0;
    end else begin
      state_q       <= state_d;
      tgt_q         <= tgt_d;
      pred_q        <= pred_d;
      redirect_pc_q <= redirect_pc_d;
      total_q       <= total_d;
      misp_q        <= misp_d;
    end
  end

  // Control outputs decode from the state register; only flush also looks at the compare.
  always_comb begin
    state_d        = state_q;
    tgt_d          = tgt_q;
    pred_d         = pred_q;
    redirect_pc_d  = redirect_pc_q;
    total_d        = total_q;
    misp_d         = misp_q;
    jalrq_rd_en    = 1'b0;
    jalr_done      = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;

    case (state_q)
      IDLE: begin
        if (commit_jalr) state_d = WAIT;
      end
      WAIT: begin
        if (!commit_jalr) begin
          state_d = IDLE;
        end else if (head_ready) begin
          tgt_d   = jalr_actual_address & ~32'h1;
          pred_d  = jalr_taken_address;
          state_d = CHECK;
        end
      end
      CHECK: begin
        jalrq_rd_en = 1'b1;
        if (total_q != '1) total_d = total_q + CNT_W'(1);
        if (tgt_q == pred_q) begin
          state_d = DONE;
        end else begin
          flush         = 1'b1;
          redirect_pc_d = tgt_q;
          if (misp_q != '1) misp_d = misp_q + CNT_W'(1);
          state_d       = REDIRECT;
        end
      end
      REDIRECT: begin
        redirect_valid = 1'b1;
        if (redirect_ack) state_d = DONE;
      end
      DONE: begin
        jalr_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign redirect_pc     = redirect_pc_q;
  assign jalr_total      = total_q;
  assign jalr_mispredict = misp_q;

endmodule

// File: tb/tb_jalr_resolve.sv
// Scoreboarded bench for jalr_resolve: directed scenarios plus random JALRs, with a
// 2-bit-counter twin instance driven in lockstep to exercise counter saturation.
module tb_jalr_resolve;

  logic        clk = 1'b0;
  logic        reset;
  logic        commit_jalr;
  logic        head_ready;
  logic [31:0] jalr_actual_address;
  logic [31:0] jalr_taken_address;
  logic        redirect_ack;

  logic        jalrq_rd_en, jalr_done, flush, redirect_valid;
  logic [31:0] redirect_pc;
  logic [15:0] jalr_total, jalr_mispredict;

  logic        sRdEn, sDone, sFlush, sRedirectValid;
  logic [31:0] sRedirectPc;
  logic [1:0]  sTotal, sMisp;

  jalr_resolve #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .commit_jalr(commit_jalr), .head_ready(head_ready),
    .jalr_actual_address(jalr_actual_address), .jalr_taken_address(jalr_taken_address),
    .jalrq_rd_en(jalrq_rd_en), .jalr_done(jalr_done), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .redirect_ack(redirect_ack),
    .jalr_total(jalr_total), .jalr_mispredict(jalr_mispredict)
  );

  jalr_resolve #(.CNT_W(2)) dutSmall (
    .clk(clk), .reset(reset), .commit_jalr(commit_jalr), .head_ready(head_ready),
    .jalr_actual_address(jalr_actual_address), .jalr_taken_address(jalr_taken_address),
    .jalrq_rd_en(sRdEn), .jalr_done(sDone), .flush(sFlush),
    .redirect_valid(sRedirectValid), .redirect_pc(sRedirectPc), .redirect_ack(redirect_ack),
    .jalr_total(sTotal), .jalr_mispredict(sMisp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        miss;
    logic [31:0] tgt;
    int          lat;
    int          rvCycles;
    int          tot;
    int          mis;
  } exp_t;

  exp_t expQ[$];
  int   rdStamps[$];
  int   totalChecks = 0;
  int   badChecks = 0;
  int   modelTotal = 0;
  int   modelMisp = 0;
  int   ackDelay = 0;
  int   cycleCount = 0;

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    totalChecks++;
    if (act !== want) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Fetch side: acknowledge once redirect_valid has been seen for ackDelay cycles.
  int rvSeen = 0;
  always @(posedge clk) begin
    #1;
    if (redirect_valid) begin
      redirect_ack = (rvSeen >= ackDelay);
      rvSeen++;
    end else begin
      redirect_ack = 1'b0;
      rvSeen = 0;
    end
  end

  // Monitor: pops the expected JALR on dequeue and checks it through to jalr_done.
  exp_t cur;
  logic inFlight = 1'b0;
  int   cyc = 0;
  int   rvCnt = 0;
  always @(negedge clk) begin
    cycleCount++;
    if (!reset) begin
      inFlight = 1'b0;
      expQ.delete();
    end else begin
      if (flush && jalr_done) checkOutput("flush_and_done_together", 1, 0);
      if (jalrq_rd_en) begin
        rdStamps.push_back(cycleCount);
        if (inFlight || expQ.size() == 0) begin
          checkOutput("unexpected_dequeue", 1, 0);
        end else begin
          cur = expQ.pop_front();
          inFlight = 1'b1;
          cyc = 0;
          rvCnt = 0;
          checkOutput("flush_on_dequeue", 32'(flush), 32'(cur.miss));
        end
      end else if (flush) begin
        checkOutput("flush_without_dequeue", 1, 0);
      end
      if (redirect_valid) begin
        if (!inFlight) checkOutput("stray_redirect_valid", 1, 0);
        else begin
          rvCnt++;
          checkOutput("redirect_pc", redirect_pc, cur.tgt);
        end
      end
      if (jalr_done) begin
        if (!inFlight) checkOutput("stray_jalr_done", 1, 0);
        else begin
          checkOutput("done_latency", 32'(cyc), 32'(cur.lat));
          checkOutput("redirect_cycles", 32'(rvCnt), 32'(cur.rvCycles));
          checkOutput("jalr_total", 32'(jalr_total), 32'(sat(cur.tot, 65535)));
          checkOutput("jalr_mispredict", 32'(jalr_mispredict), 32'(sat(cur.mis, 65535)));
          checkOutput("small_total", 32'(sTotal), 32'(sat(cur.tot, 3)));
          checkOutput("small_mispredict", 32'(sMisp), 32'(sat(cur.mis, 3)));
          inFlight = 1'b0;
        end
      end
      if (inFlight) cyc++;
    end
  end

  // One JALR: present operands, release head_ready after headDelay cycles, and
  // return during the jalr_done cycle (commit held over if keepCommit).
  task automatic applyStimulus(input logic [31:0] actual, input logic [31:0] taken,
                               input int headDelay, input int ackDly, input bit keepCommit);
    exp_t e;
    bit   seenDone = 0;
    e.tgt      = actual & 32'hFFFF_FFFE;
    e.miss     = (e.tgt != taken);
    modelTotal++;
    if (e.miss) modelMisp++;
    e.tot      = modelTotal;
    e.mis      = modelMisp;
    e.lat      = e.miss ? ackDly + 2 : 1;
    e.rvCycles = e.miss ? ackDly + 1 : 0;
    expQ.push_back(e);
    ackDelay            = ackDly;
    commit_jalr         = 1'b1;
    jalr_actual_address = actual;
    jalr_taken_address  = taken;
    head_ready          = (headDelay == 0);
    for (int c = 0; c < headDelay; c++) @(posedge clk) #1;
    head_ready = 1'b1;
    for (int c = 0; c < 200 && !seenDone; c++) begin
      @(posedge clk) #1;
      seenDone = jalr_done;
    end
    if (!seenDone) checkOutput("jalr_done_timeout", 0, 1);
    if (!keepCommit) begin
      commit_jalr = 1'b0;
      head_ready  = 1'b0;
    end
  endtask

  initial begin
    int   doneCount;
    bit   seen;
    logic [31:0] a, t;

    reset = 1'b0;
    commit_jalr = 1'b0;
    head_ready = 1'b0;
    jalr_actual_address = '0;
    jalr_taken_address = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_outputs", {jalrq_rd_en, jalr_done, flush, redirect_valid}, 0);
    checkOutput("reset_redirect_pc", redirect_pc, 0);
    checkOutput("reset_counters", {jalr_total, jalr_mispredict}, 0);
    reset = 1'b1;
    @(posedge clk) #1;

    $display("[TB] hit after reset");
    applyStimulus(32'h0000_1005, 32'h0000_1004, 0, 0, 0);

    $display("[TB] miss with delayed ack");
    applyStimulus(32'h0000_2000, 32'h0000_1004, 0, 3, 0);

    $display("[TB] wait then abort");
    commit_jalr = 1'b1;
    head_ready = 1'b0;
    repeat (5) @(posedge clk) #1;
    commit_jalr = 1'b0;
    repeat (3) @(posedge clk) #1;
    checkOutput("abort_total", 32'(jalr_total), 32'(modelTotal));
    checkOutput("abort_mispredict", 32'(jalr_mispredict), 32'(modelMisp));

    $display("[TB] back-to-back hits");
    rdStamps.delete();
    applyStimulus(32'h0000_3000, 32'h0000_3000, 0, 0, 1);
    applyStimulus(32'h0000_4003, 32'h0000_4002, 0, 0, 0);
    @(posedge clk) #1;
    checkOutput("b2b_dequeues", 32'(rdStamps.size()), 2);
    if (rdStamps.size() == 2)
      checkOutput("b2b_spacing", 32'(rdStamps[1] - rdStamps[0]), 4);

    $display("[TB] async reset in redirect");
    ackDelay = 1000;
    expQ.push_back('{miss: 1'b1, tgt: 32'h0000_5000, lat: 0, rvCycles: 0, tot: 0, mis: 0});
    commit_jalr = 1'b1;
    head_ready = 1'b1;
    jalr_actual_address = 32'h0000_5000;
    jalr_taken_address = 32'h0000_6000;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk) #1;
      seen = redirect_valid;
    end
    checkOutput("redirect_reached", 32'(seen), 1);
    @(posedge clk) #2;
    reset = 1'b0;
    #1;
    checkOutput("rst_redirect_valid", 32'(redirect_valid), 0);
    checkOutput("rst_redirect_pc", redirect_pc, 0);
    checkOutput("rst_counters", {jalr_total, jalr_mispredict}, 0);
    checkOutput("rst_controls", {jalrq_rd_en, jalr_done, flush}, 0);
    modelTotal = 0;
    modelMisp = 0;
    commit_jalr = 1'b0;
    head_ready = 1'b0;
    @(posedge clk) #1;
    reset = 1'b1;
    doneCount = 0;
    repeat (6) begin
      @(posedge clk) #1;
      if (jalr_done) doneCount++;
    end
    checkOutput("no_done_after_reset", 32'(doneCount), 0);

    $display("[TB] saturation on 2-bit counters");
    for (int i = 0; i < 5; i++)
      applyStimulus(32'h0000_7000 + 32'(i * 16), 32'h0000_0100, 0, i % 2, 0);
    @(posedge clk) #1;
    checkOutput("sat_total", 32'(sTotal), 3);
    checkOutput("sat_mispredict", 32'(sMisp), 3);

    $display("[TB] random JALRs");
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case ($urandom_range(0, 2))
        0:       t = a & 32'hFFFF_FFFE;
        1:       t = (a & 32'hFFFF_FFFE) ^ 32'h2;
        default: t = $urandom;
      endcase
      applyStimulus(a, t, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    commit_jalr = 1'b0;
    head_ready = 1'b0;
    repeat (3) @(posedge clk) #1;
    checkOutput("final_total", 32'(jalr_total), 32'(modelTotal));
    checkOutput("final_mispredict", 32'(jalr_mispredict), 32'(modelMisp));
    checkOutput("final_small_total", 32'(sTotal), 3);
    checkOutput("scoreboard_drained", 32'(expQ.size()), 0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
